crc_ahb_feeder: RTL and testbench
=================================

CRC_AHB_FEEDER -- requirements
Module: crc_ahb_feeder

Interface
REQ-001 SHALL have parameter CRC_BASE, default 32'h4002_3000, meaning AHB base address of the CRC slave.
REQ-002 SHALL have parameter DR_OFFSET, default 32'h0, meaning offset of the CRC data register, used for both data writes and the result read.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: command pulse.
REQ-006 SHALL have port src_addr, input, 32 bits: source buffer start address; bits [1:0] are ignored and forced to 0.
REQ-007 SHALL have port word_count, input, 16 bits: number of 32-bit words to feed.
REQ-008 SHALL have port busy, output, 1 bit: command in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port error, output, 1 bit: last command aborted by HRESP; held until the next start.
REQ-011 SHALL have port crc_result, output, 32 bits: value read from CRC_BASE+DR_OFFSET; held until the next start.
REQ-012 SHALL have AHB-Lite master outputs: HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0] and HWDATA[31:0].
REQ-013 SHALL have AHB-Lite master inputs: HRDATA[31:0], HREADY and HRESP.

Function
REQ-014 SHALL drive HSIZE=3'b010, HBURST=3'b000 (SINGLE) and HPROT=4'b0011 constantly.
REQ-015 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, RES_ADDR, RES_DATA, DONE.
REQ-016 SHALL sample start only in IDLE; when sampled, SHALL register src_addr and word_count, clear error and crc_result, and go to RD_ADDR, or to RES_ADDR if word_count==0.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL drive busy=1 in every state except IDLE.
REQ-019 In each *_ADDR state, SHALL drive HTRANS=NONSEQ (2'b10) with the address below; the state SHALL advance to its *_DATA state on the first edge with HREADY=1.
REQ-020 The addresses SHALL be: RD_ADDR uses the current read pointer with HWRITE=0; WR_ADDR uses CRC_BASE+DR_OFFSET with HWRITE=1; RES_ADDR uses CRC_BASE+DR_OFFSET with HWRITE=0.
REQ-021 In every non-ADDR state, SHALL drive HTRANS=IDLE (2'b00) and HWRITE=0; HADDR SHALL hold its last value.
REQ-022 A data phase SHALL complete on an edge with HREADY=1 and HRESP=0; while HREADY=0 the state SHALL hold.
REQ-023 RD_DATA completion SHALL capture HRDATA into a data register and go to WR_ADDR.
REQ-024 In WR_DATA, SHALL drive HWDATA from the data register.
REQ-025 WR_DATA completion SHALL increment the read pointer by 4, decrement the remaining count, and go to RD_ADDR if remaining>0, else to RES_ADDR.
REQ-026 RES_DATA completion SHALL load crc_result from HRDATA and go to DONE.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 HRESP=1 seen in any *_DATA state SHALL set error=1, drive HTRANS=IDLE, and go to DONE on the edge where HREADY=1 (second cycle of the two-cycle error response); crc_result SHALL stay 0.
REQ-029 The read pointer SHALL wrap modulo 2^32 at 32'hFFFF_FFFC.
REQ-030 With zero wait states, done SHALL assert 4*word_count+3 cycles after the start-sampling edge.

Reset
REQ-031 While HRESETn=0, immediately and regardless of HCLK: state=IDLE, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, crc_result=0, internal pointer/count/data=0.
REQ-032 Reset asserted mid-transfer SHALL abandon the command; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 src_addr=0x2000_0000, word_count=2, zero waits, memory {0x11111111, 0x22222222}, slave DR read returns 0xDEADBEEF -> bus sequence: R 0x20000000, W 0x40023000 data 0x11111111, R 0x20000004, W 0x40023000 data 0x22222222, R 0x40023000; done at cycle 11; crc_result=0xDEADBEEF; error=0.
REQ-034 word_count=0 -> only the result read at 0x40023000 occurs; done at cycle 3.
REQ-035 Slave inserts 3 HREADY=0 cycles in each data phase, word_count=1 -> each state holds with HWDATA stable; done at cycle 3+4+3*3=16.
REQ-036 Two-cycle HRESP error on the second read, word_count=4 -> no further NONSEQ issued, error=1, done pulses once, crc_result=0.
REQ-037 Pulse start while busy, and src_addr=0xFFFF_FFFC with word_count=2 -> the extra start is ignored; second read address is 0x0000_0000.
REQ-038 HRESETn driven low mid-WR_DATA -> HTRANS=IDLE and busy=0 within the same cycle; a new command after release completes normally.

Source files
------------

// File: rtl/crc_ahb_feeder.sv
// AHB-Lite master that streams a word buffer from memory into a CRC data register,
// then reads the CRC result back from the same register.
module crc_ahb_feeder #(
    parameter logic [31:0] CRC_BASE  = 32'h4002_3000,
    parameter logic [31:0] DR_OFFSET = 32'h0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] crc_result,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [31:0] DR_ADDR = CRC_BASE + DR_OFFSET;
    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, RES_ADDR, RES_DATA, DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ptr;
    logic [15:0] r_remain;
    logic [31:0] r_data;
    logic [31:0] r_haddr;
    logic [31:0] r_crc;
    logic        r_error;
    logic [31:0] w_src_aligned;
    logic        w_is_data;
    logic        w_data_ok;

    assign w_src_aligned = src_addr & 32'hFFFF_FFFC;
    assign w_is_data     = (r_state == RD_DATA) || (r_state == WR_DATA) || (r_state == RES_DATA);
    assign w_data_ok     = HREADY && !HRESP;

    // An error response ends the command as soon as its second (HREADY=1) cycle arrives.
    always_comb begin
        w_next = r_state;
        HTRANS = TR_IDLE;
        HWRITE = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = (word_count == '0) ? RES_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                HTRANS = TR_NONSEQ;
                if (HREADY) w_next = RD_DATA;
            end
            RD_DATA: begin
                if (HREADY) w_next = HRESP ? DONE : WR_ADDR;
            end
            WR_ADDR: begin
                HTRANS = TR_NONSEQ;
                HWRITE = 1'b1;
                if (HREADY) w_next = WR_DATA;
            end
            WR_DATA: begin
                if (HREADY) begin
                    if (HRESP)                  w_next = DONE;
                    else if (r_remain > 16'd1)  w_next = RD_ADDR;
                    else                        w_next = RES_ADDR;
                end
            end
            RES_ADDR: begin
                HTRANS = TR_NONSEQ;
                if (HREADY) w_next = RES_DATA;
            end
            RES_DATA: begin
                if (HREADY) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // HADDR is loaded on the edge that enters an address state and held afterwards.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_remain <= '0;
            r_data   <= '0;
            r_haddr  <= '0;
            r_crc    <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_is_data && HRESP) r_error <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr    <= w_src_aligned;
                        r_remain <= word_count;
                        r_error  <= 1'b0;
                        r_crc    <= '0;
                        r_haddr  <= (word_count == '0) ? DR_ADDR : w_src_aligned;
                    end
                end
                RD_DATA: begin
                    if (w_data_ok) begin
                        r_data  <= HRDATA;
                        r_haddr <= DR_ADDR;
                    end
                end
                WR_DATA: begin
                    if (w_data_ok) begin
                        r_ptr    <= r_ptr + 32'd4;
                        r_remain <= r_remain - 16'd1;
                        r_haddr  <= (r_remain > 16'd1) ? (r_ptr + 32'd4) : DR_ADDR;
                    end
                end
                RES_DATA: begin
                    if (w_data_ok) r_crc <= HRDATA;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign error      = r_error;
    assign crc_result = r_crc;
    assign HADDR      = r_haddr;
    assign HWDATA     = r_data;
    assign HSIZE      = 3'b010;
    assign HBURST     = 3'b000;
    assign HPROT      = 4'b0011;

endmodule

// File: tb/tb_crc_ahb_feeder.sv
// Bench for crc_ahb_feeder: AHB slave model with wait/error injection, a transfer
// scoreboard, a table of command vectors and a mid-transfer reset sequence.
module tb_crc_ahb_feeder;

    localparam logic [31:0] DR = 32'h4002_3000;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [31:0] src_addr;
    logic [15:0] word_count;
    logic        busy, done, error;
    logic [31:0] crc_result;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;

    crc_ahb_feeder dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .crc_result(crc_result), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
    } xfer_t;

    typedef struct {
        logic [31:0] src;
        logic [15:0] wc;
        int          waits;
        int          err_idx;
        logic [31:0] dr;
        int          exp_done;
        logic [31:0] exp_crc;
        logic        exp_err;
        bit          extra;
    } vec_t;

    xfer_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_n;
    int          err_at;
    logic [31:0] dr_val;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h2000_0000) return 32'h1111_1111;
        if (a == 32'h2000_0004) return 32'h2222_2222;
        return a ^ 32'h5EED_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model: registered HREADY/HRESP, per-transfer wait states, two-cycle error.
    logic        s_act = 1'b0;
    logic        s_wr  = 1'b0;
    logic        s_err = 1'b0;
    logic [31:0] s_addr = '0;
    int          s_cnt = 0;
    int          xfer_cnt = 0;

    assign HRDATA = s_wr ? 32'h0 : ((s_addr == DR) ? dr_val : mem_val(s_addr));

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            s_act  <= 1'b0;
            s_err  <= 1'b0;
            HREADY <= 1'b1;
            HRESP  <= 1'b0;
        end else if (s_act && !HREADY) begin
            if (s_err) begin
                HREADY <= 1'b1;
            end else begin
                if (s_cnt == 1) HREADY <= 1'b1;
                s_cnt <= s_cnt - 1;
            end
        end else begin
            s_act  <= 1'b0;
            s_err  <= 1'b0;
            HREADY <= 1'b1;
            HRESP  <= 1'b0;
            if (HTRANS == 2'b10) begin
                s_act    <= 1'b1;
                s_addr   <= HADDR;
                s_wr     <= HWRITE;
                xfer_cnt <= xfer_cnt + 1;
                if (xfer_cnt == err_at) begin
                    s_err  <= 1'b1;
                    HREADY <= 1'b0;
                    HRESP  <= 1'b1;
                end else if (wait_n > 0) begin
                    HREADY <= 1'b0;
                    s_cnt  <= wait_n;
                end
            end
        end
    end

    // Bus monitor: address phases against the scoreboard, write data during data phases.
    xfer_t       mon_e;
    logic [31:0] mon_wd = '0;

    always @(negedge HCLK) begin
        if (HRESETn === 1'b1) begin
            if (HTRANS == 2'b10 && HREADY) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_nonseq: addr %h write %0b, no transfer expected", HADDR, HWRITE);
                end else begin
                    mon_e = sb.pop_front();
                    check("haddr", HADDR, mon_e.addr);
                    check("hwrite", {31'b0, HWRITE}, {31'b0, mon_e.wr});
                    mon_wd = mon_e.wd;
                end
            end
            if (s_act && s_wr && !HRESP) check("hwdata", HWDATA, mon_wd);
        end
    end

    task automatic push_expected(input vec_t v);
        xfer_t       list[$];
        logic [31:0] p;
        int          lim;
        p = v.src & 32'hFFFF_FFFC;
        for (int i = 0; i < int'(v.wc); i++) begin
            list.push_back('{p, 1'b0, 32'h0});
            list.push_back('{DR, 1'b1, mem_val(p)});
            p = p + 32'd4;
        end
        list.push_back('{DR, 1'b0, 32'h0});
        lim = (v.err_idx >= 0) ? v.err_idx + 1 : list.size();
        for (int i = 0; i < lim; i++) sb.push_back(list[i]);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        bit got;
        wait_n = v.waits;
        dr_val = v.dr;
        err_at = (v.err_idx >= 0) ? xfer_cnt + v.err_idx : -1;
        push_expected(v);
        @(negedge HCLK);
        start = 1'b1; src_addr = v.src; word_count = v.wc;
        @(negedge HCLK);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        check({tag, "_crc_cleared"}, crc_result, 32'h0);
        check({tag, "_err_cleared"}, {31'b0, error}, 32'd0);
        got = 1'b0;
        while (!got && cyc < 300) begin
            if (done) got = 1'b1;
            else begin
                @(negedge HCLK);
                cyc++;
                start = (v.extra && cyc == 3);
                if (start) begin
                    src_addr = 32'h5555_0000; word_count = 16'd7;
                end
            end
        end
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen after %0d cycles, required at %0d", tag, cyc, v.exp_done);
        end else begin
            check({tag, "_done_cycle"}, cyc, v.exp_done);
        end
        check({tag, "_crc"}, crc_result, v.exp_crc);
        check({tag, "_error"}, {31'b0, error}, {31'b0, v.exp_err});
        @(negedge HCLK);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        repeat (3) @(negedge HCLK);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
        check({tag, "_crc_held"}, crc_result, v.exp_crc);
        check({tag, "_error_held"}, {31'b0, error}, {31'b0, v.exp_err});
    endtask

    vec_t vecs[6];

    initial begin
        // src, wc, waits, err_idx, dr, done cycle, crc, error, extra start
        vecs[0] = '{32'h2000_0000, 16'd2, 0, -1, 32'hDEAD_BEEF, 11, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[1] = '{32'h3000_0003, 16'd0, 0, -1, 32'hCAFE_F00D,  3, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[2] = '{32'h2000_0000, 16'd1, 3, -1, 32'h0BAD_F00D, 16, 32'h0BAD_F00D, 1'b0, 1'b0};
        vecs[3] = '{32'h1000_0013, 16'd4, 0,  2, 32'h7777_7777,  8, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, 16'd2, 0, -1, 32'h5A5A_5A5A, 11, 32'h5A5A_5A5A, 1'b0, 1'b1};
        vecs[5] = '{32'h2000_0101, 16'd3, 1, -1, 32'h0102_0304, 22, 32'h0102_0304, 1'b0, 1'b0};

        HRESETn = 1'b1; start = 1'b0; src_addr = '0; word_count = '0;
        wait_n = 0; err_at = -1; dr_val = '0;
        #2 HRESETn = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_crc", crc_result, 32'h0);
        check("rst_htrans", {30'b0, HTRANS}, 32'd0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwrite", {31'b0, HWRITE}, 32'd0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("hsize", {29'b0, HSIZE}, 32'd2);
        check("hburst", {29'b0, HBURST}, 32'd0);
        check("hprot", {28'b0, HPROT}, 32'd3);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while the first write data phase is in progress.
        wait_n = 0; err_at = -1;
        sb.push_back('{32'h2000_0040, 1'b0, 32'h0});
        sb.push_back('{DR, 1'b1, mem_val(32'h2000_0040)});
        @(negedge HCLK);
        start = 1'b1; src_addr = 32'h2000_0040; word_count = 16'd3;
        @(posedge HCLK);
        #1 start = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("mid_wr_busy", {31'b0, busy}, 32'd1);
        check("mid_wr_hwdata", HWDATA, mem_val(32'h2000_0040));
        #1 HRESETn = 1'b0;
        #1;
        check("arst_htrans", {30'b0, HTRANS}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_haddr", HADDR, 32'h0);
        check("arst_hwdata", HWDATA, 32'h0);
        check("arst_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        check("arst_sb_empty", sb.size(), 32'd0);
        repeat (3) @(negedge HCLK);
        check("arst_idle_busy", {31'b0, busy}, 32'd0);
        run_vec(vecs[0], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule
